vec_issue_sequencer: RTL

Multi-beat issue sequencer that sits directly upstream of `execute_unit`. It accepts one vector instruction at a time over a valid/ready handshake and reads operand chunks from the vector register file (synchronous-read, one-cycle latency). It drives `execute_unit`'s `a`, `b`, `pe_op`, `dot_prod_en` and `shift` inputs one chunk per cycle. It also emits the writeback strobes that tell the register-file write port when and where to capture `elem_out` or `dot_out`.

---
 rtl/vec_issue_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/vec_issue_sequencer.sv
// Multi-beat vector issue sequencer: walks operand chunks out of a sync-read
// register file, drives execute_unit one chunk per cycle, and times the writeback strobes.
module vec_issue_sequencer #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 4,
    parameter int EXEC_LAT   = 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           instr_valid_i,
    output logic                           instr_ready_o,
    input  logic [1:0]                     instr_op_i,
    input  logic                           instr_dot_i,
    input  logic [ADDR_WIDTH-1:0]          instr_src_a_i,
    input  logic [ADDR_WIDTH-1:0]          instr_src_b_i,
    input  logic [ADDR_WIDTH-1:0]          instr_dst_i,
    input  logic [LEN_WIDTH-1:0]           instr_len_i,
    output logic [ADDR_WIDTH-1:0]          rf_raddr_a_o,
    output logic [ADDR_WIDTH-1:0]          rf_raddr_b_o,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] rf_rdata_b_i,
    output logic [PE_COUNT*DATA_WIDTH-1:0] a_o,
    output logic [PE_COUNT*DATA_WIDTH-1:0] b_o,
    output logic [1:0]                     pe_op_o,
    output logic                           dot_prod_en_o,
    output logic                           shift_o,
    output logic                           wb_en_o,
    output logic [ADDR_WIDTH-1:0]          wb_addr_o,
    output logic                           wb_sel_o,
    output logic                           busy_o
);

    localparam int DEPTH = 2 + EXEC_LAT;
    localparam int LANES = PE_COUNT * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  accept_s;
    logic [1:0]            op_q;
    logic                  dot_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  last_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [ADDR_WIDTH-1:0] raddr_a_q, raddr_b_q;

    logic                  issue_s, first_s, last_s, wb_s, sel_s;
    logic [ADDR_WIDTH-1:0] addr_s;

    logic [DEPTH-1:0]      pv_q, pl_q, pw_q, ps_q;
    logic                  pf0_q;
    logic [ADDR_WIDTH-1:0] pa_q [DEPTH];

    logic [LANES-1:0]      a_q, b_q;
    logic [1:0]            pe_op_q;
    logic                  dot_en_q, shift_q;

    assign accept_s = instr_valid_i && (state_q == IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; drain ends once the last beat leaves the writeback stage
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = ISSUE;
                else          state_d = IDLE;
            end
            ISSUE: begin
                if (beat_q == last_q) state_d = DRAIN;
                else                  state_d = ISSUE;
            end
            DRAIN: begin
                if (pv_q[DEPTH-1] && pl_q[DEPTH-1]) state_d = IDLE;
                else                                state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        instr_ready_o = 1'b0;
        busy_o        = 1'b1;
        case (state_q)
            IDLE: begin
                instr_ready_o = 1'b1;
                busy_o        = 1'b0;
            end
            default: begin
                instr_ready_o = 1'b0;
                busy_o        = 1'b1;
            end
        endcase
    end

    // Instruction latch, beat counter and read-address generation
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q      <= 2'b00;
            dot_q     <= 1'b0;
            dst_q     <= '0;
            last_q    <= '0;
            beat_q    <= '0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
        end else if (accept_s) begin
            op_q      <= instr_op_i;
            dot_q     <= instr_dot_i;
            dst_q     <= instr_dst_i;
            last_q    <= (instr_len_i == '0) ? '0 : instr_len_i - LEN_WIDTH'(1);
            beat_q    <= '0;
            raddr_a_q <= instr_src_a_i;
            raddr_b_q <= instr_src_b_i;
        end else if (state_q == ISSUE) begin
            beat_q    <= beat_q + LEN_WIDTH'(1);
            raddr_a_q <= raddr_a_q + ADDR_WIDTH'(1);
            raddr_b_q <= raddr_b_q + ADDR_WIDTH'(1);
        end else begin
            beat_q    <= beat_q;
            raddr_a_q <= raddr_a_q;
            raddr_b_q <= raddr_b_q;
        end
    end

    assign rf_raddr_a_o = raddr_a_q;
    assign rf_raddr_b_o = raddr_b_q;

    // Per-beat tag formed in the address cycle; dot products write once, to dst
    always_comb begin
        issue_s = 1'b0;
        first_s = 1'b0;
        last_s  = 1'b0;
        wb_s    = 1'b0;
        sel_s   = 1'b0;
        addr_s  = '0;
        if (state_q == ISSUE) begin
            issue_s = 1'b1;
            first_s = (beat_q == '0);
            last_s  = (beat_q == last_q);
            wb_s    = !dot_q || (beat_q == last_q);
            sel_s   = dot_q;
            addr_s  = dot_q ? dst_q : dst_q + ADDR_WIDTH'(beat_q);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Beat pipeline: entry j holds the beat whose address cycle was j+1 cycles ago
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pv_q  <= '0;
            pl_q  <= '0;
            pw_q  <= '0;
            ps_q  <= '0;
            pf0_q <= 1'b0;
            for (int j = 0; j < DEPTH; j++) pa_q[j] <= '0;
        end else begin
            pv_q  <= {pv_q[DEPTH-2:0], issue_s};
            pl_q  <= {pl_q[DEPTH-2:0], last_s};
            pw_q  <= {pw_q[DEPTH-2:0], wb_s};
            ps_q  <= {ps_q[DEPTH-2:0], sel_s};
            pf0_q <= first_s;
            pa_q[0] <= addr_s;
            for (int j = 1; j < DEPTH; j++) pa_q[j] <= pa_q[j-1];
        end
    end

    // Operand register: captures read data while a beat sits in the rdata cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_q      <= '0;
            b_q      <= '0;
            pe_op_q  <= 2'b00;
            dot_en_q <= 1'b0;
            shift_q  <= 1'b0;
        end else if (pv_q[0]) begin
            a_q      <= rf_rdata_a_i;
            b_q      <= rf_rdata_b_i;
            pe_op_q  <= dot_q ? 2'b11 : op_q;
            dot_en_q <= dot_q;
            shift_q  <= dot_q && pf0_q;
        end else begin
            a_q      <= a_q;
            b_q      <= b_q;
            pe_op_q  <= pe_op_q;
            dot_en_q <= 1'b0;
            shift_q  <= 1'b0;
        end
    end

    assign a_o           = a_q;
    assign b_o           = b_q;
    assign pe_op_o       = pe_op_q;
    assign dot_prod_en_o = dot_en_q;
    assign shift_o       = shift_q;
    assign wb_en_o       = pw_q[DEPTH-1];
    assign wb_addr_o     = pa_q[DEPTH-1];
    assign wb_sel_o      = ps_q[DEPTH-1];

endmodule
